soc_system_sysid_reader: RTL and testbench
==========================================

SOC_SYSTEM_SYSID_READER -- requirements
Module: soc_system_sysid_reader

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clock and reset.
REQ-002 Parameter EXPECTED_ID, default 32'hACD51302, SHALL be the expected system ID word at address 0.
REQ-003 Parameter EXPECTED_TS, default 32'h5279E721, SHALL be the expected timestamp word at address 1.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024, range 2..65535, SHALL be the per-transaction cycle limit.
REQ-005 Ports SHALL be (name direction width meaning):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle request to run a check
- avm_address  out  1  Avalon-MM word address: 0=ID, 1=timestamp
- avm_read  out  1  Avalon-MM read request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data qualifier
- busy  out  1  check in progress
- done  out  1  one-cycle pulse when a check ends
- id_match  out  1  captured ID equals EXPECTED_ID
- ts_match  out  1  captured timestamp equals EXPECTED_TS
- pass  out  1  id_match AND ts_match AND no timeout
- timeout  out  1  check aborted by timeout
- id_value  out  32  captured ID word
- ts_value  out  32  captured timestamp word

Function
REQ-006 FSM states SHALL be IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, FINISH.
REQ-007 In IDLE, start=1 SHALL move to REQ_ID on the next edge and clear id_match, ts_match, pass, timeout, id_value and ts_value.
REQ-008 start SHALL be ignored in every state except IDLE.
REQ-009 In REQ_ID/REQ_TS, avm_read SHALL be 1 with avm_address 0/1, held stable until a cycle with avm_waitrequest=0, then move to WAIT_ID/WAIT_TS.
REQ-010 avm_read SHALL be 0 in all states other than REQ_ID and REQ_TS; exactly one read SHALL be accepted per REQ state.
REQ-011 avm_readdatavalid SHALL be sampled only in WAIT_ID/WAIT_TS; outside these states it SHALL be ignored (including late data after a timeout).
REQ-012 In WAIT_ID, avm_readdatavalid=1 SHALL capture avm_readdata into id_value and move to REQ_TS; in WAIT_TS it SHALL capture into ts_value and move to FINISH.
REQ-013 In FINISH, id_match and ts_match SHALL be computed by full 32-bit equality, pass updated, done=1 for exactly that cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 Result outputs SHALL hold their values from FINISH until the next accepted start or reset.
REQ-016 Minimum check latency SHALL be 5 cycles from start to done when waitrequest=0 and readdatavalid arrives the cycle after acceptance.

Reset
REQ-017 reset=1 at a clock edge SHALL force IDLE and drive avm_read, avm_address, busy, done, id_match, ts_match, pass, timeout to 0 and id_value, ts_value to 0, whatever the current state.
REQ-018 Reset mid-transaction SHALL abandon the transaction with no done pulse; avm_read SHALL be 0 from the cycle after the reset edge.
REQ-019 reset SHALL take priority over start in the same cycle.

Configuration
REQ-020 With macro SYSID_READER_TIMEOUT_EN defined, a counter SHALL restart to 0 on entry to each REQ state and count each cycle in REQ and WAIT states; reaching TIMEOUT_CYCLES-1 without completion SHALL move to FINISH with timeout=1, pass=0, id_match/ts_match=0, avm_read dropped.
REQ-021 Without SYSID_READER_TIMEOUT_EN, no counter SHALL be built, timeout SHALL be constant 0, and the FSM SHALL wait indefinitely in REQ and WAIT states.

Verification
REQ-022 Slave returns 32'hACD51302 then 32'h5279E721, no stalls, 1-cycle latency; start pulse -> done at cycle 5, pass=1, id_match=1, ts_match=1.
REQ-023 Slave returns ID 32'h00000001 -> done, id_match=0, ts_match=1, pass=0, id_value=32'h00000001.
REQ-024 waitrequest held 3 cycles on each read, readdatavalid 4 cycles later -> avm_read/avm_address stable during stall, two reads accepted, pass=1.
REQ-025 Macro defined, TIMEOUT_CYCLES=16, slave never asserts readdatavalid -> done 16 cycles after ID acceptance, timeout=1, pass=0; later readdatavalid ignored.
REQ-026 reset asserted in WAIT_TS, then start again -> no done before reset; busy=0 after reset; second check completes with pass=1.
REQ-027 start re-pulsed while busy -> ignored; exactly one done, exactly two reads issued.

Source files
------------

// File: rtl/soc_system_sysid_reader_if.sv
// Avalon-MM read-only link between the sysid reader (master) and the sysid slave.
// Word address 0 holds the system ID, word address 1 holds the build timestamp.
interface soc_system_sysid_reader_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );
endinterface

// File: rtl/soc_system_sysid_reader.sv
// SoC sysid reader: on a start pulse, reads the ID word (address 0) and the
// timestamp word (address 1) over Avalon-MM, compares them to the expected
// build values and reports match/pass with a one-cycle done pulse.
// Optional feature macro: SYSID_READER_TIMEOUT_EN -- adds a per-transaction
// cycle limit (TIMEOUT_CYCLES); without it the reader waits indefinitely and
// timeout is tied to 0.
module soc_system_sysid_reader #(
    parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
    parameter logic [31:0] EXPECTED_TS    = 32'h5279E721,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    soc_system_sysid_reader_if.master avm,
    output logic                      busy,
    output logic                      done,
    output logic                      id_match,
    output logic                      ts_match,
    output logic                      pass,
    output logic                      timeout,
    output logic [31:0]               id_value,
    output logic [31:0]               ts_value
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_ID  = 3'd1,
        WAIT_ID = 3'd2,
        REQ_TS  = 3'd3,
        WAIT_TS = 3'd4,
        FINISH  = 3'd5
    } state_t;

    state_t state, state_n;
    logic   tmo_fire;   // transaction limit reached without completion this cycle
    logic   go;         // accepted start

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 2..65535");
    end

    assign go   = (state == IDLE) && start;
    assign busy = (state != IDLE);

`ifdef SYSID_READER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt;
    logic        timeout_q;

    assign tmo_fire = (tmo_cnt == TMO_LAST) &&
                      (((state == REQ_ID  || state == REQ_TS ) &&  avm.avm_waitrequest) ||
                       ((state == WAIT_ID || state == WAIT_TS) && !avm.avm_readdatavalid));
    assign timeout  = timeout_q;

    // Restart on entry to each request phase, then count every REQ/WAIT cycle.
    always_ff @(posedge clock) begin
        if (reset)
            tmo_cnt <= '0;
        else if ((state_n == REQ_ID && state != REQ_ID) ||
                 (state_n == REQ_TS && state != REQ_TS))
            tmo_cnt <= '0;
        else if (state != IDLE && state != FINISH)
            tmo_cnt <= tmo_cnt + 16'd1;
    end

    // Timeout flag: set on abort, cleared by a new check, held otherwise.
    always_ff @(posedge clock) begin
        if (reset || go)
            timeout_q <= 1'b0;
        else if (tmo_fire)
            timeout_q <= 1'b1;
    end
`else
    assign tmo_fire = 1'b0;
    assign timeout  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next state and bus/status outputs; read stays asserted and stable until accepted.
    always_comb begin
        state_n         = state;
        avm.avm_read    = 1'b0;
        avm.avm_address = 1'b0;
        done            = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_n = REQ_ID;
            end
            REQ_ID: begin
                avm.avm_read = 1'b1;
                if (!avm.avm_waitrequest) state_n = WAIT_ID;
                else if (tmo_fire)        state_n = FINISH;
            end
            WAIT_ID: begin
                if (avm.avm_readdatavalid) state_n = REQ_TS;
                else if (tmo_fire)         state_n = FINISH;
            end
            REQ_TS: begin
                avm.avm_read    = 1'b1;
                avm.avm_address = 1'b1;
                if (!avm.avm_waitrequest) state_n = WAIT_TS;
                else if (tmo_fire)        state_n = FINISH;
            end
            WAIT_TS: begin
                if (avm.avm_readdatavalid) state_n = FINISH;
                else if (tmo_fire)         state_n = FINISH;
            end
            FINISH: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Capture and compare results so they are valid while done is high, then hold.
    always_ff @(posedge clock) begin
        if (reset || go) begin
            id_value <= '0;
            ts_value <= '0;
            id_match <= 1'b0;
            ts_match <= 1'b0;
            pass     <= 1'b0;
        end else if (state == WAIT_ID && avm.avm_readdatavalid) begin
            id_value <= avm.avm_readdata;
        end else if (state == WAIT_TS && avm.avm_readdatavalid) begin
            ts_value <= avm.avm_readdata;
            id_match <= (id_value == EXPECTED_ID);
            ts_match <= (avm.avm_readdata == EXPECTED_TS);
            pass     <= (id_value == EXPECTED_ID) && (avm.avm_readdata == EXPECTED_TS);
        end else if (tmo_fire) begin
            id_match <= 1'b0;
            ts_match <= 1'b0;
            pass     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_soc_system_sysid_reader.sv
// Bench for soc_system_sysid_reader: a behavioural Avalon slave with
// configurable stall/latency, directed scenarios and randomized checks
// against a transaction-level timing and result model.
module tb_soc_system_sysid_reader;

    localparam logic [31:0] EXP_ID = 32'hACD51302;
    localparam logic [31:0] EXP_TS = 32'h5279E721;
    localparam int          TMO    = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, done, id_match, ts_match, pass, timeout;
    logic [31:0] id_value, ts_value;

    soc_system_sysid_reader_if bus();

    soc_system_sysid_reader #(
        .EXPECTED_ID   (EXP_ID),
        .EXPECTED_TS   (EXP_TS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .avm     (bus),
        .busy    (busy),
        .done    (done),
        .id_match(id_match),
        .ts_match(ts_match),
        .pass    (pass),
        .timeout (timeout),
        .id_value(id_value),
        .ts_value(ts_value)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Slave configuration, written only by the stimulus process.
    int          stall_cfg = 0;
    int          lat_cfg   = 1;
    bit          respond   = 1'b1;
    logic [31:0] id_word   = EXP_ID;
    logic [31:0] ts_word   = EXP_TS;
    int          late_due  = -1;

    // Slave/monitor state, written only by the slave process.
    int          n         = 0;
    int          reads     = 0;
    int          dones     = 0;
    int          done_n    = 0;
    int          stall_err = 0;
    bit          in_req    = 1'b0;
    int          stall_left;
    logic        req_addr;
    int          pend_due[$];
    logic [31:0] pend_dat[$];
    logic        addr_log[$];

    // Behavioural slave and monitor, evaluated mid-cycle away from the active edge.
    always @(negedge clock) begin
        n++;
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = $urandom;
        bus.avm_waitrequest   = 1'b0;
        if (reset) begin
            pend_due.delete();
            pend_dat.delete();
            in_req = 1'b0;
        end else begin
            if (pend_due.size() > 0 && pend_due[0] == n) begin
                bus.avm_readdatavalid = 1'b1;
                bus.avm_readdata      = pend_dat[0];
                void'(pend_due.pop_front());
                void'(pend_dat.pop_front());
            end
            if (n == late_due) begin
                bus.avm_readdatavalid = 1'b1;
                bus.avm_readdata      = 32'h0BADF00D;
            end
            if (bus.avm_read) begin
                if (!in_req) begin
                    in_req     = 1'b1;
                    stall_left = stall_cfg;
                    req_addr   = bus.avm_address;
                end else if (bus.avm_address !== req_addr) begin
                    stall_err++;
                end
                if (stall_left > 0) begin
                    bus.avm_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    in_req = 1'b0;
                    reads++;
                    addr_log.push_back(bus.avm_address);
                    if (respond) begin
                        pend_due.push_back(n + lat_cfg);
                        pend_dat.push_back(bus.avm_address ? ts_word : id_word);
                    end
                end
            end else if (in_req) begin
                stall_err++;
                in_req = 1'b0;
            end
        end
        if (done) begin
            dones++;
            done_n = n;
        end
    end

    // Start-to-done cycles: one to leave IDLE, then per read (s+1) request cycles plus l wait cycles.
    function automatic int exp_latency(input int s, input int l);
        return 1 + 2 * ((s + 1) + l);
    endfunction

    function automatic logic [31:0] pick(input logic [31:0] good);
        case ($urandom_range(0, 2))
            0:       return good;
            1:       return good ^ (32'h1 << $urandom_range(0, 31));
            default: return $urandom;
        endcase
    endfunction

    task automatic do_run(input string nm, input int s, input int l,
                          input logic [31:0] idw, input logic [31:0] tsw, input bit repulse);
        int d0, r0, e0, st_n;
        stall_cfg = s;
        lat_cfg   = l;
        id_word   = idw;
        ts_word   = tsw;
        respond   = 1'b1;
        d0 = dones;
        r0 = reads;
        e0 = stall_err;
        @(posedge clock); #2;
        start = 1'b1;
        st_n  = n + 1;
        @(posedge clock); #2;
        start = 1'b0;
        if (repulse) begin
            @(posedge clock); #2;
            start = 1'b1;
            @(posedge clock); #2;
            start = 1'b0;
        end
        for (int i = 0; i < 200 && dones == d0; i++) @(posedge clock);
        repeat (8) @(posedge clock);
        #2;
        chk({nm, ":done_cnt"}, dones - d0, 1);
        chk({nm, ":latency"}, done_n - st_n, exp_latency(s, l));
        chk({nm, ":reads"}, reads - r0, 2);
        if (addr_log.size() >= r0 + 2)
            chk({nm, ":addr_order"}, {addr_log[r0], addr_log[r0 + 1]}, 2'b01);
        chk({nm, ":stall_stable"}, stall_err - e0, 0);
        chk({nm, ":id_value"}, id_value, idw);
        chk({nm, ":ts_value"}, ts_value, tsw);
        chk({nm, ":id_match"}, id_match, idw == EXP_ID);
        chk({nm, ":ts_match"}, ts_match, tsw == EXP_TS);
        chk({nm, ":pass"}, pass, (idw == EXP_ID) && (tsw == EXP_TS));
        chk({nm, ":timeout"}, timeout, 0);
        chk({nm, ":idle"}, {busy, bus.avm_read, done}, 3'b000);
    endtask

    initial begin
        int d0, r0, st_n;
        // Reset with start held high: reset must win.
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        chk("rst:busy", busy, 0);
        chk("rst:bus", {bus.avm_read, bus.avm_address}, 2'b00);
        chk("rst:done", done, 0);
        chk("rst:flags", {id_match, ts_match, pass, timeout}, 4'b0000);
        chk("rst:id_value", id_value, 0);
        chk("rst:ts_value", ts_value, 0);
        start = 1'b0;
        reset = 1'b0;

        do_run("basic",   0, 1, EXP_ID,       EXP_TS, 1'b0);
        do_run("bad_id",  0, 1, 32'h00000001, EXP_TS, 1'b0);
        do_run("stall",   3, 4, EXP_ID,       EXP_TS, 1'b0);
        do_run("repulse", 0, 1, EXP_ID,       EXP_TS, 1'b1);

        // Reset during WAIT_TS: transaction abandoned, no done, then a clean rerun.
        stall_cfg = 0;
        lat_cfg   = 6;
        respond   = 1'b1;
        id_word   = EXP_ID;
        ts_word   = EXP_TS;
        d0 = dones;
        r0 = reads;
        @(posedge clock); #2;
        start = 1'b1;
        @(posedge clock); #2;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #2;
        chk("midrst:busy_before", busy, 1);
        chk("midrst:reads_before", reads - r0, 2);
        reset = 1'b1;
        @(posedge clock); #2;
        chk("midrst:busy", busy, 0);
        chk("midrst:read", bus.avm_read, 0);
        chk("midrst:id_value", id_value, 0);
        reset = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        chk("midrst:no_done", dones - d0, 0);
        do_run("after_rst", 0, 1, EXP_ID, EXP_TS, 1'b0);

`ifdef SYSID_READER_TIMEOUT_EN
        // Slave never answers: abort TMO cycles after the ID read is accepted.
        respond   = 1'b0;
        stall_cfg = 0;
        lat_cfg   = 1;
        d0 = dones;
        r0 = reads;
        @(posedge clock); #2;
        start = 1'b1;
        st_n  = n + 1;
        @(posedge clock); #2;
        start = 1'b0;
        for (int i = 0; i < 200 && dones == d0; i++) @(posedge clock);
        #2;
        chk("tmo:latency", done_n - st_n, 1 + TMO);
        late_due = n + 2;
        repeat (6) @(posedge clock);
        #2;
        chk("tmo:done_cnt", dones - d0, 1);
        chk("tmo:reads", reads - r0, 1);
        chk("tmo:timeout", timeout, 1);
        chk("tmo:flags", {pass, id_match, ts_match}, 3'b000);
        chk("tmo:late_ignored", {id_value, ts_value}, 64'h0);
        chk("tmo:idle", {busy, bus.avm_read}, 2'b00);
        respond = 1'b1;
`else
        st_n = 0;
`endif

        for (int k = 0; k < 16; k++) begin
            logic [31:0] idw, tsw;
            idw = pick(EXP_ID);
            tsw = pick(EXP_TS);
            do_run($sformatf("rnd%0d", k), int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                   idw, tsw, bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, %0d checks so far", n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
